ucmd_dispatch: RTL and testbench

//  Command front-end for the micro-sequencer. Accepts Frodo operation requests (op + parameter set + tag)

---
 rtl/ucmd_pkg.sv | 68 ++++++
 rtl/ucmd_fifo.sv | 52 +++++
 rtl/ucmd_dispatch.sv | 153 +++++++++++++++
 tb/tb_ucmd_dispatch.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucmd_pkg.sv
// Shared types and tables for the micro-sequencer command front-end:
// opcodes, parameter sets, entry addresses, loop bounds and FSM states.
package ucmd_pkg;

    localparam int LOOP_W = 11;

    typedef enum logic [2:0] {
        OP_KEYGEN   = 3'd0,
        OP_ENCAPS   = 3'd1,
        OP_DECAPS   = 3'd2,
        OP_SELFTEST = 3'd3
    } op_e;

    typedef enum logic [1:0] {
        PSET_640  = 2'd0,
        PSET_976  = 2'd1,
        PSET_1344 = 2'd2
    } pset_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_BUSY   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    // Entry 8'h00 is the sequencer idle address and is never handed out.
    localparam logic [7:0] UPC_KEYGEN   = 8'h01;
    localparam logic [7:0] UPC_ENCAPS   = 8'h40;
    localparam logic [7:0] UPC_DECAPS   = 8'h90;
    localparam logic [7:0] UPC_SELFTEST = 8'hF0;

    typedef struct packed {
        logic [LOOP_W-1:0] l4;
        logic [LOOP_W-1:0] l3;
        logic [LOOP_W-1:0] l2;
        logic [LOOP_W-1:0] l1;
        logic [LOOP_W-1:0] l0;
    } loops_t;

    function automatic logic cmd_legal(input logic [2:0] op, input logic [1:0] pset);
        return (op <= OP_SELFTEST) && (pset <= PSET_1344);
    endfunction

    function automatic logic [7:0] entry_addr(input logic [2:0] op);
        case (op)
            OP_KEYGEN:   return UPC_KEYGEN;
            OP_ENCAPS:   return UPC_ENCAPS;
            OP_DECAPS:   return UPC_DECAPS;
            OP_SELFTEST: return UPC_SELFTEST;
            default:     return 8'h00;
        endcase
    endfunction

    // n/8, 8, n/16, n/4, n for n = 640 / 976 / 1344
    function automatic loops_t loop_bounds(input logic [1:0] pset);
        loops_t lb;
        lb = '0;
        case (pset)
            PSET_640:  lb = '{l4: 11'd640,  l3: 11'd160, l2: 11'd40, l1: 11'd8, l0: 11'd80};
            PSET_976:  lb = '{l4: 11'd976,  l3: 11'd244, l2: 11'd61, l1: 11'd8, l0: 11'd122};
            PSET_1344: lb = '{l4: 11'd1344, l3: 11'd336, l2: 11'd84, l1: 11'd8, l0: 11'd168};
            default:   lb = '0;
        endcase
        return lb;
    endfunction

endpackage

// File: rtl/ucmd_fifo.sv
// Small synchronous command FIFO with full/empty flags.
// Push while full and pop while empty are dropped internally.
module ucmd_fifo
    import ucmd_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic          push_ok, pop_ok;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rptr_q];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop_ok)  rptr_q <= rptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/ucmd_dispatch.sv
// Command front-end: queues Frodo requests, launches the sequencer with entry
// address and loop bounds, waits for done and returns a tagged, timed response.
module ucmd_dispatch
    import ucmd_pkg::*;
#(
    parameter int UINST_ADDR_WIDTH = 8,
    parameter int TAG_W            = 4,
    parameter int CYC_W            = 24,
    parameter int CMD_DEPTH        = 2
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [2:0]                  cmd_op,
    input  logic [1:0]                  cmd_pset,
    input  logic [TAG_W-1:0]            cmd_tag,
    output logic                        start_pos,
    output logic [UINST_ADDR_WIDTH-1:0] upc_start,
    output logic [LOOP_W-1:0]           loop_0,
    output logic [LOOP_W-1:0]           loop_1,
    output logic [LOOP_W-1:0]           loop_2,
    output logic [LOOP_W-1:0]           loop_3,
    output logic [LOOP_W-1:0]           loop_4,
    input  logic                        done,
    output logic                        busy,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [TAG_W-1:0]            rsp_tag,
    output logic                        rsp_err,
    output logic [CYC_W-1:0]            rsp_cycles
);

    localparam int FW = TAG_W + 5;

    logic [FW-1:0]    head;
    logic             full, empty, pop;
    logic [2:0]       head_op;
    logic [1:0]       head_pset;
    logic [TAG_W-1:0] head_tag;

    ucmd_fifo #(.DEPTH(CMD_DEPTH), .W(FW)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (cmd_valid),
        .wdata ({cmd_op, cmd_pset, cmd_tag}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign head_op   = head[FW-1 -: 3];
    assign head_pset = head[TAG_W+1 -: 2];
    assign head_tag  = head[TAG_W-1:0];

    state_e                      state_q, state_d;
    logic [CYC_W-1:0]            cnt_q, cnt_d;
    logic [CYC_W-1:0]            cnt_inc;
    logic [UINST_ADDR_WIDTH-1:0] upc_q, upc_d;
    loops_t                      loops_q, loops_d;
    logic [TAG_W-1:0]            tag_q, tag_d;
    logic [TAG_W-1:0]            rsp_tag_q, rsp_tag_d;
    logic                        rsp_err_q, rsp_err_d;
    logic [CYC_W-1:0]            rsp_cyc_q, rsp_cyc_d;

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            upc_q     <= '0;
            loops_q   <= '0;
            tag_q     <= '0;
            rsp_tag_q <= '0;
            rsp_err_q <= 1'b0;
            rsp_cyc_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            upc_q     <= upc_d;
            loops_q   <= loops_d;
            tag_q     <= tag_d;
            rsp_tag_q <= rsp_tag_d;
            rsp_err_q <= rsp_err_d;
            rsp_cyc_q <= rsp_cyc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        upc_d     = upc_q;
        loops_d   = loops_q;
        tag_d     = tag_q;
        rsp_tag_d = rsp_tag_q;
        rsp_err_d = rsp_err_q;
        rsp_cyc_d = rsp_cyc_q;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (cmd_legal(head_op, head_pset)) begin
                        upc_d   = UINST_ADDR_WIDTH'(entry_addr(head_op));
                        loops_d = loop_bounds(head_pset);
                        tag_d   = head_tag;
                        state_d = ST_LAUNCH;
                    end else begin
                        rsp_err_d = 1'b1;
                        rsp_cyc_d = '0;
                        rsp_tag_d = head_tag;
                        state_d   = ST_RESP;
                    end
                end
            end
            // done is ignored here: the sequencer gives start_pos priority.
            ST_LAUNCH: begin
                cnt_d   = CYC_W'(1);
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                cnt_d = cnt_inc;
                if (done) begin
                    rsp_cyc_d = cnt_inc;
                    rsp_err_d = 1'b0;
                    rsp_tag_d = tag_q;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cmd_ready  = !full;
    assign start_pos  = (state_q == ST_LAUNCH);
    assign busy       = (state_q != ST_IDLE);
    assign rsp_valid  = (state_q == ST_RESP);
    assign upc_start  = upc_q;
    assign loop_0     = loops_q.l0;
    assign loop_1     = loops_q.l1;
    assign loop_2     = loops_q.l2;
    assign loop_3     = loops_q.l3;
    assign loop_4     = loops_q.l4;
    assign rsp_tag    = rsp_tag_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_cycles = rsp_cyc_q;

endmodule

// File: tb/tb_ucmd_dispatch.sv
// Self-checking bench for ucmd_dispatch: directed scenarios plus a randomized
// run against a table-driven reference model with a behavioural sequencer.
module tb_ucmd_dispatch;

    localparam int AW = 8;
    localparam int TW = 4;
    localparam int CW = 24;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = '0;
    logic [1:0]    cmd_pset = '0;
    logic [TW-1:0] cmd_tag = '0;
    logic          start_pos;
    logic [AW-1:0] upc_start;
    logic [10:0]   loop_0, loop_1, loop_2, loop_3, loop_4;
    logic          done = 1'b0;
    logic          busy;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [TW-1:0] rsp_tag;
    logic          rsp_err;
    logic [CW-1:0] rsp_cycles;

    ucmd_dispatch #(.UINST_ADDR_WIDTH(AW), .TAG_W(TW), .CYC_W(CW), .CMD_DEPTH(2)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_pset(cmd_pset), .cmd_tag(cmd_tag),
        .start_pos(start_pos), .upc_start(upc_start),
        .loop_0(loop_0), .loop_1(loop_1), .loop_2(loop_2), .loop_3(loop_3), .loop_4(loop_4),
        .done(done), .busy(busy),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
        .rsp_err(rsp_err), .rsp_cycles(rsp_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {int op; int pset; int tag;} cmd_t;
    typedef struct {int upc; int l0; int l1; int l2; int l3; int l4; int dly;} launch_t;
    typedef struct {int tag; int err; int cyc;} rsp_t;

    cmd_t    exp_q[$];
    launch_t launch_q[$];
    rsp_t    rsp_q[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int seq_delay = 10;
    bit rand_delay = 0;
    bit early_done = 0;
    bit rsp_hold = 0;
    bit bp_rand = 0;
    int stab_err = 0;
    int sp_double = 0;

    // reference tables
    function automatic bit legal(int op, int pset);
        return op < 4 && pset < 3;
    endfunction
    function automatic int entry(int op);
        int t[4];
        t = '{8'h01, 8'h40, 8'h90, 8'hF0};
        return t[op];
    endfunction
    function automatic int nsz(int p);
        return (p == 0) ? 640 : (p == 1) ? 976 : 1344;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural sequencer + response sink + stability observer.
    int          due = 0;
    bit          pend = 0, have_cur = 0, hold_seen = 0, sp_last = 0;
    logic [62:0] cur_lp;
    logic [TW+CW:0] rsp_prev;
    always @(negedge clk) begin
        int d;
        done = 1'b0;
        rsp_ready = rsp_hold ? 1'b0 : (bp_rand ? 1'($urandom_range(0, 1)) : 1'b1);
        if (!rstn) begin
            pend = 0; have_cur = 0; hold_seen = 0; sp_last = 0;
        end else begin
            if (start_pos) begin
                d = rand_delay ? int'($urandom_range(1, 12)) : seq_delay;
                launch_q.push_back('{int'(upc_start), int'(loop_0), int'(loop_1), int'(loop_2),
                                     int'(loop_3), int'(loop_4), d});
                pend = 1; due = cyc + d;
                if (early_done) done = 1'b1;
                cur_lp = {upc_start, loop_0, loop_1, loop_2, loop_3, loop_4};
                have_cur = 1;
            end else if (have_cur && {upc_start, loop_0, loop_1, loop_2, loop_3, loop_4} !== cur_lp)
                stab_err++;
            if (pend && cyc == due) begin done = 1'b1; pend = 0; end
            if (start_pos && sp_last) sp_double++;
            if (start_pos && rsp_valid) stab_err++;
            sp_last = start_pos;
            if (hold_seen && (!rsp_valid || {rsp_tag, rsp_err, rsp_cycles} !== rsp_prev)) stab_err++;
            if (rsp_valid && rsp_ready)
                rsp_q.push_back('{int'(rsp_tag), int'(rsp_err), int'(rsp_cycles)});
            hold_seen = rsp_valid && !rsp_ready;
            rsp_prev  = {rsp_tag, rsp_err, rsp_cycles};
        end
    end

    task automatic push_cmd(input int op, input int pset, input int tag);
        int n = 0;
        while (!cmd_ready && n < 500) begin cmd_valid = 1'b0; @(negedge clk); n++; end
        if (!cmd_ready) begin
            vectors++; miscompares++;
            $display("FAIL push_timeout: cmd_ready stayed %b, want 1", cmd_ready);
        end else begin
            cmd_valid = 1'b1; cmd_op = 3'(op); cmd_pset = 2'(pset); cmd_tag = TW'(tag);
            exp_q.push_back('{op, pset, tag});
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsps(input int target, input int budget);
        int n = 0;
        while (rsp_q.size() < target && n < budget) begin @(negedge clk); n++; end
        if (rsp_q.size() < target) begin
            vectors++; miscompares++;
            $display("FAIL rsp_timeout: got %0d responses, want %0d", rsp_q.size(), target);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if ({start_pos, busy, rsp_valid, rsp_err} !== 4'b0) begin miscompares++;
            $display("FAIL rst_flags: got %b, want 0000", {start_pos, busy, rsp_valid, rsp_err}); end
        vectors++; if (cmd_ready !== 1'b1) begin miscompares++;
            $display("FAIL rst_cmd_ready: got %b, want 1", cmd_ready); end
        vectors++; if ({upc_start, loop_0, loop_1, loop_2, loop_3, loop_4} !== 63'd0) begin miscompares++;
            $display("FAIL rst_launch_fields: got %h, want 0", {upc_start, loop_0, loop_1, loop_2, loop_3, loop_4}); end
        vectors++; if ({rsp_tag, rsp_cycles} !== '0) begin miscompares++;
            $display("FAIL rst_rsp_fields: got %h, want 0", {rsp_tag, rsp_cycles}); end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_encaps();
        int lb = launch_q.size(), rb = rsp_q.size(), sb = sp_double;
        seq_delay = 10;
        push_cmd(1, 1, 5);
        wait_rsps(rb + 1, 100);
        vectors++; if (launch_q.size() != lb + 1) begin miscompares++;
            $display("FAIL enc_launches: got %0d, want 1", launch_q.size() - lb); end
        else begin
            vectors++; if (launch_q[lb].upc != 'h40) begin miscompares++;
                $display("FAIL enc_upc: got %h, want 40", launch_q[lb].upc); end
            vectors++; if (launch_q[lb].l0 != 122 || launch_q[lb].l4 != 976) begin miscompares++;
                $display("FAIL enc_loops: got %0d/%0d, want 122/976", launch_q[lb].l0, launch_q[lb].l4); end
        end
        if (rsp_q.size() > rb) begin
            vectors++; if (rsp_q[rb].tag != 5 || rsp_q[rb].err != 0) begin miscompares++;
                $display("FAIL enc_rsp: got tag %0d err %0d, want 5 0", rsp_q[rb].tag, rsp_q[rb].err); end
            vectors++; if (rsp_q[rb].cyc != 11) begin miscompares++;
                $display("FAIL enc_cycles: got %0d, want 11", rsp_q[rb].cyc); end
        end
        vectors++; if (sp_double != sb) begin miscompares++;
            $display("FAIL enc_pulse_width: got %0d long pulses, want 0", sp_double - sb); end
    endtask

    task automatic test_illegal();
        int lb = launch_q.size(), rb = rsp_q.size();
        push_cmd(6, $urandom_range(0, 3), 3);
        push_cmd($urandom_range(0, 3), 3, 4);
        wait_rsps(rb + 2, 100);
        repeat (3) @(negedge clk);
        vectors++; if (launch_q.size() != lb) begin miscompares++;
            $display("FAIL ill_launch: got %0d launches, want 0", launch_q.size() - lb); end
        for (int i = 0; i < 2; i++) if (rsp_q.size() > rb + i) begin
            vectors++;
            if (rsp_q[rb+i].tag != 3 + i || rsp_q[rb+i].err != 1 || rsp_q[rb+i].cyc != 0) begin
                miscompares++;
                $display("FAIL ill_rsp%0d: got tag %0d err %0d cyc %0d, want %0d 1 0", i,
                         rsp_q[rb+i].tag, rsp_q[rb+i].err, rsp_q[rb+i].cyc, 3 + i);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lb = launch_q.size(), rb = rsp_q.size(), sb = stab_err;
        int tags[4], upcs[4];
        tags = '{1, 2, 3, 4};
        upcs = '{8'h01, 8'h90, 8'hF0, 8'h40};
        seq_delay = 30;
        push_cmd(0, 0, 1);
        repeat (3) @(negedge clk);
        vectors++; if (busy !== 1'b1) begin miscompares++;
            $display("FAIL b2b_busy: got %b, want 1", busy); end
        push_cmd(2, 2, 2);
        push_cmd(3, 1, 3);
        vectors++; if (cmd_ready !== 1'b0) begin miscompares++;
            $display("FAIL b2b_full: cmd_ready got %b, want 0", cmd_ready); end
        push_cmd(1, 0, 4);
        wait_rsps(rb + 4, 400);
        for (int i = 0; i < 4; i++) begin
            if (rsp_q.size() > rb + i) begin
                vectors++; if (rsp_q[rb+i].tag != tags[i] || rsp_q[rb+i].cyc != 31) begin miscompares++;
                    $display("FAIL b2b_rsp%0d: got tag %0d cyc %0d, want %0d 31", i,
                             rsp_q[rb+i].tag, rsp_q[rb+i].cyc, tags[i]); end
            end
            if (launch_q.size() > lb + i) begin
                vectors++; if (launch_q[lb+i].upc != upcs[i]) begin miscompares++;
                    $display("FAIL b2b_upc%0d: got %h, want %h", i, launch_q[lb+i].upc, upcs[i]); end
            end
        end
        vectors++; if (stab_err != sb) begin miscompares++;
            $display("FAIL b2b_stable: got %0d glitches, want 0", stab_err - sb); end
    endtask

    task automatic test_early_done();
        int rb = rsp_q.size();
        early_done = 1; seq_delay = 4;
        push_cmd(3, 0, 7);
        wait_rsps(rb + 1, 100);
        early_done = 0;
        if (rsp_q.size() > rb) begin
            vectors++; if (rsp_q[rb].cyc != 5 || rsp_q[rb].tag != 7) begin miscompares++;
                $display("FAIL early_done: got cyc %0d tag %0d, want 5 7", rsp_q[rb].cyc, rsp_q[rb].tag); end
        end
    endtask

    task automatic test_rsp_hold();
        int lb = launch_q.size(), rb = rsp_q.size(), sb = stab_err, n = 0;
        rsp_hold = 1; seq_delay = 3;
        push_cmd(2, 1, 9);
        push_cmd(0, 2, 10);
        while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        repeat (20) @(negedge clk);
        vectors++; if (rsp_valid !== 1'b1 || rsp_tag !== 4'd9 || rsp_cycles !== 24'd4) begin miscompares++;
            $display("FAIL hold_fields: got v%b tag %0d cyc %0d, want v1 9 4", rsp_valid, rsp_tag, rsp_cycles); end
        vectors++; if (launch_q.size() != lb + 1) begin miscompares++;
            $display("FAIL hold_no_launch: got %0d launches, want 1", launch_q.size() - lb); end
        vectors++; if (rsp_q.size() != rb) begin miscompares++;
            $display("FAIL hold_no_accept: got %0d accepted, want 0", rsp_q.size() - rb); end
        rsp_hold = 0;
        wait_rsps(rb + 2, 100);
        if (rsp_q.size() > rb + 1) begin
            vectors++; if (rsp_q[rb].tag != 9 || rsp_q[rb+1].tag != 10 || rsp_q[rb+1].cyc != 4) begin miscompares++;
                $display("FAIL hold_order: got %0d,%0d cyc %0d, want 9,10 cyc 4",
                         rsp_q[rb].tag, rsp_q[rb+1].tag, rsp_q[rb+1].cyc); end
        end
        vectors++; if (stab_err != sb) begin miscompares++;
            $display("FAIL hold_stable: got %0d glitches, want 0", stab_err - sb); end
    endtask

    task automatic test_reset_mid();
        int lb, rb;
        seq_delay = 50;
        push_cmd(1, 0, 11);
        push_cmd(2, 1, 12);
        repeat (6) @(negedge clk);
        vectors++; if (busy !== 1'b1) begin miscompares++;
            $display("FAIL mid_busy: got %b, want 1", busy); end
        rstn = 1'b0;
        #1;
        vectors++; if ({start_pos, busy, rsp_valid, rsp_err, upc_start, loop_0, loop_4, rsp_tag, rsp_cycles} !== '0
                       || cmd_ready !== 1'b1) begin miscompares++;
            $display("FAIL mid_reset_outputs: busy %b upc %h loop0 %0d ready %b, want 0 0 0 1",
                     busy, upc_start, loop_0, cmd_ready); end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        lb = launch_q.size(); rb = rsp_q.size();
        repeat (80) @(negedge clk);
        vectors++; if (launch_q.size() != lb || rsp_q.size() != rb || busy !== 1'b0) begin miscompares++;
            $display("FAIL mid_abandon: got %0d launches %0d rsps busy %b, want 0 0 0",
                     launch_q.size() - lb, rsp_q.size() - rb, busy); end
    endtask

    task automatic test_random();
        int eb = exp_q.size(), lb = launch_q.size(), rb = rsp_q.size(), li, sb = stab_err;
        cmd_t c; rsp_t r; launch_t l; int n;
        bp_rand = 1; rand_delay = 1;
        for (int i = 0; i < 30; i++) begin
            push_cmd($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 15));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_rsps(rb + 30, 3000);
        bp_rand = 0; rand_delay = 0;
        li = lb;
        for (int i = 0; i < 30 && rb + i < rsp_q.size(); i++) begin
            c = exp_q[eb+i]; r = rsp_q[rb+i];
            vectors++; if (r.tag != c.tag) begin miscompares++;
                $display("FAIL rnd%0d_tag: got %0d, want %0d", i, r.tag, c.tag); end
            if (legal(c.op, c.pset) && li < launch_q.size()) begin
                l = launch_q[li]; li++; n = nsz(c.pset);
                vectors++;
                if (l.upc != entry(c.op) || l.l0 != n / 8 || l.l1 != 8 || l.l2 != n / 16
                    || l.l3 != n / 4 || l.l4 != n) begin miscompares++;
                    $display("FAIL rnd%0d_launch: got %h %0d %0d %0d %0d %0d, want %h %0d 8 %0d %0d %0d", i,
                             l.upc, l.l0, l.l1, l.l2, l.l3, l.l4, entry(c.op), n / 8, n / 16, n / 4, n); end
                vectors++; if (r.err != 0 || r.cyc != l.dly + 1) begin miscompares++;
                    $display("FAIL rnd%0d_rsp: got err %0d cyc %0d, want 0 %0d", i, r.err, r.cyc, l.dly + 1); end
            end else begin
                vectors++; if (r.err != 1 || r.cyc != 0) begin miscompares++;
                    $display("FAIL rnd%0d_err: got err %0d cyc %0d, want 1 0", i, r.err, r.cyc); end
            end
        end
        vectors++; if (launch_q.size() != li) begin miscompares++;
            $display("FAIL rnd_launch_count: got %0d, want %0d", launch_q.size() - lb, li - lb); end
        vectors++; if (stab_err != sb) begin miscompares++;
            $display("FAIL rnd_stable: got %0d glitches, want 0", stab_err - sb); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_encaps();
        test_illegal();
        test_back_to_back();
        test_early_done();
        test_rsp_hold();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
